// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: ROM port, branch redirect, and the IF/ID valid/ready handshake.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;

  modport master (
    input  branch_flag_i, branch_target_i, rom_inst, out_ready,
    output rom_ce, rom_addr, out_valid, out_pc, out_inst
  );

  modport slave (
    output branch_flag_i, branch_target_i, rom_inst, out_ready,
    input  rom_ce, rom_addr, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, ROM access and a small {pc, inst} FIFO
// feeding IF/ID, with branch redirect that flushes anything already fetched.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_reg;
  logic [31:0]      pc_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];

  logic ce_q;
  logic full;
  logic push;
  logic pop;

  assign ce_q = (state_reg == ST_RUN);
  // DEPTH is a power of two, so the count MSB alone means "full".
  assign full = count_reg[PTR_W];
  assign pop  = bus.out_valid & bus.out_ready;
  // A full FIFO that is popping this cycle still accepts the new instruction.
  assign push = ce_q & ~bus.branch_flag_i & (~full | pop);

  assign bus.rom_ce    = ce_q;
  assign bus.rom_addr  = ce_q ? pc_reg : 32'h0;
  assign bus.out_valid = (count_reg != '0);
  assign bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr_reg]   : 32'h0;
  assign bus.out_inst  = bus.out_valid ? inst_mem[rd_ptr_reg] : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_WAIT;
      pc_reg     <= RESET_PC;
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      state_reg <= ST_RUN;
      if (bus.branch_flag_i) begin
        // Redirect wins over everything; a pop in the same cycle is dropped.
        pc_reg     <= bus.branch_target_i & 32'hFFFF_FFFC;
        count_reg  <= '0;
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
      end else begin
        if (push) begin
          pc_reg     <= pc_reg + 32'd4;
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Storage carries no reset; out_* are gated by out_valid so stale data never leaks.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= pc_reg;
      inst_mem[wr_ptr_reg] <= bus.rom_inst;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scoreboard of expected PCs, refilled on
// every reset or redirect, is popped each time IF/ID accepts an entry.
module tb_fetch_unit;
  logic clk;
  logic rst;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ROM model: word i holds 32'h3400_0000 + i.
  assign bus.rom_inst = 32'h3400_0000 + {2'b00, bus.rom_addr[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          n_accepts = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_fill_pc;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h3400_0000 + {2'b00, a[31:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic restart(input logic [31:0] start_pc);
    exp_q.delete();
    next_fill_pc = start_pc;
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_fill_pc);
      next_fill_pc = next_fill_pc + 32'd4;
    end
  endtask

  // Called at a falling edge: drive inputs, score any handshake, advance one cycle.
  task automatic step(input logic rdy, input logic br, input logic [31:0] tgt);
    logic [31:0] e;
    logic [31:0] aligned;
    bus.out_ready       = rdy;
    bus.branch_flag_i   = br;
    bus.branch_target_i = tgt;
    aligned             = tgt;
    if (br) restart({aligned[31:2], 2'b00});
    top_up();
    if (bus.out_valid === 1'b1 && rdy && !br) begin
      e = exp_q.pop_front();
      chk("out_pc", bus.out_pc, e);
      chk("out_inst", bus.out_inst, rom_word(e));
      n_accepts++;
      $display("accept pc=%h inst=%h", bus.out_pc, bus.out_inst);
    end else if (bus.out_valid !== 1'b1) begin
      chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_out_pc", bus.out_pc, 32'h0);
      chk("idle_out_inst", bus.out_inst, 32'h0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int acc_before;
    rst                 = 1'b0;
    bus.out_ready       = 1'b1;
    bus.branch_flag_i   = 1'b0;
    bus.branch_target_i = 32'h0;
    restart(32'h0);
    repeat (2) @(negedge clk);

    chk("rst_rom_ce", 32'(bus.rom_ce), 32'd0);
    chk("rst_rom_addr", bus.rom_addr, 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_inst", bus.out_inst, 32'h0);

    // Startup latency.
    rst = 1'b1;
    step(1'b1, 1'b0, 32'h0);
    chk("e1_rom_ce", 32'(bus.rom_ce), 32'd1);
    chk("e1_out_valid", 32'(bus.out_valid), 32'd0);
    chk("e1_rom_addr", bus.rom_addr, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("e2_out_valid", 32'(bus.out_valid), 32'd1);
    chk("e2_out_pc", bus.out_pc, 32'h0);
    chk("e2_out_inst", bus.out_inst, 32'h3400_0000);

    // Backpressure: FIFO fills and the fetch address freezes.
    repeat (5) step(1'b0, 1'b0, 32'h0);
    chk("bp_rom_addr", bus.rom_addr, 32'h8);
    chk("bp_head_pc", bus.out_pc, 32'h0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Branch with full FIFO and a concurrent pop.
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0103);
    chk("br_out_valid", 32'(bus.out_valid), 32'd0);
    chk("br_rom_addr", bus.rom_addr, 32'h0000_0100);
    step(1'b1, 1'b0, 32'h0);
    chk("br1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("br1_out_pc", bus.out_pc, 32'h0000_0100);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // Back-to-back branches: the later target wins.
    step(1'b1, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b1, 32'h0000_0300);
    chk("b2b_out_valid", 32'(bus.out_valid), 32'd0);
    chk("b2b_rom_addr", bus.rom_addr, 32'h0000_0300);
    repeat (3) step(1'b1, 1'b0, 32'h0);

    // PC wrap-around.
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Asynchronous reset between edges while the FIFO is full.
    repeat (3) step(1'b0, 1'b0, 32'h0);
    chk("pre_arst_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_rom_ce", 32'(bus.rom_ce), 32'd0);
    chk("arst_rom_addr", bus.rom_addr, 32'h0);
    restart(32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) step(1'b1, 1'b0, 32'h0);

    // Random backpressure, no branches.
    acc_before = n_accepts;
    repeat (1000) step(1'($urandom_range(0, 1)), 1'b0, 32'h0);
    chk("rand_accepts", 32'((n_accepts - acc_before) > 300), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
